cam_cmd_issue: RTL and testbench

CAM_CMD_ISSUE -- requirements
Module: cam_cmd_issue

---
 rtl/cam_cmd_issue.sv | 163 ++++++++++++++++
 tb/tb_cam_cmd_issue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cmd_issue.sv
`timescale 1ns/1ps
// Command buffer and issue stage for a CAM: in-order FIFO, one strobe per command.
// Optional macro CAM_CMD_BYPASS_EN lets a command skip an empty FIFO straight into the issue stage.
module cam_cmd_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_index_i,
    input  logic [DATA_WIDTH-1:0]         cmd_data_i,
    input  logic                          hold_i,
    output logic                          read_o,
    output logic [ADDR_WIDTH-1:0]         read_index_o,
    output logic                          write_o,
    output logic [ADDR_WIDTH-1:0]         write_index_o,
    output logic [DATA_WIDTH-1:0]         write_data_o,
    output logic                          search_o,
    output logic [DATA_WIDTH-1:0]         search_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          illegal_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [1:0]       OP_NOP     = 2'b00;
    localparam logic [1:0]       OP_READ    = 2'b01;
    localparam logic [1:0]       OP_WRITE   = 2'b10;
    localparam logic [1:0]       OP_SEARCH  = 2'b11;
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   COUNT_ZERO = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [1:0]            op_mem_r    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] index_mem_r [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r  [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        count_r;

    logic                  iss_valid_r;
    logic [1:0]            iss_op_r;
    logic [ADDR_WIDTH-1:0] iss_index_r;
    logic [DATA_WIDTH-1:0] iss_data_r;

    logic accept_s;
    logic legal_s;
    logic pop_s;
    logic push_s;
    logic bypass_s;

    // Ready depends on occupancy alone so upstream never sees a valid->ready loop.
    assign cmd_ready_o = (count_r < COUNT_FULL);
    assign count_o     = count_r;

    // Handshake decode: accept, push, pop and optional bypass decisions.
    always_comb begin
        accept_s = cmd_valid_i & cmd_ready_o;
        legal_s  = accept_s & (cmd_op_i != OP_NOP);
        pop_s    = (count_r != COUNT_ZERO) & ~hold_i;
`ifdef CAM_CMD_BYPASS_EN
        bypass_s = legal_s & (count_r == COUNT_ZERO) & ~hold_i;
`else
        bypass_s = 1'b0;
`endif
        push_s   = legal_s & ~bypass_s;
    end

    // Command storage; contents are don't-care until a push makes them live.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            op_mem_r[wr_ptr_r]    <= cmd_op_i;
            index_mem_r[wr_ptr_r] <= cmd_index_i;
            data_mem_r[wr_ptr_r]  <= cmd_data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue stage: loaded from the FIFO head on a pop, or from the input on bypass.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            iss_valid_r <= 1'b0;
            iss_op_r    <= OP_NOP;
            iss_index_r <= {ADDR_WIDTH{1'b0}};
            iss_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            iss_valid_r <= pop_s | bypass_s;
            if (pop_s) begin
                iss_op_r    <= op_mem_r[rd_ptr_r];
                iss_index_r <= index_mem_r[rd_ptr_r];
                iss_data_r  <= data_mem_r[rd_ptr_r];
            end else if (bypass_s) begin
                iss_op_r    <= cmd_op_i;
                iss_index_r <= cmd_index_i;
                iss_data_r  <= cmd_data_i;
            end
        end
    end

    // Decoder-side strobes; hold is not consulted here, so an issued command always strobes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            read_o        <= 1'b0;
            write_o       <= 1'b0;
            search_o      <= 1'b0;
            illegal_o     <= 1'b0;
            read_index_o  <= {ADDR_WIDTH{1'b0}};
            write_index_o <= {ADDR_WIDTH{1'b0}};
            write_data_o  <= {DATA_WIDTH{1'b0}};
            search_data_o <= {DATA_WIDTH{1'b0}};
        end else begin
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            search_o  <= 1'b0;
            illegal_o <= accept_s & (cmd_op_i == OP_NOP);
            if (iss_valid_r) begin
                case (iss_op_r)
                    OP_READ: begin
                        read_o       <= 1'b1;
                        read_index_o <= iss_index_r;
                    end
                    OP_WRITE: begin
                        write_o       <= 1'b1;
                        write_index_o <= iss_index_r;
                        write_data_o  <= iss_data_r;
                    end
                    OP_SEARCH: begin
                        search_o      <= 1'b1;
                        search_data_o <= iss_data_r;
                    end
                    default: begin
                        read_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cam_cmd_issue.sv
`timescale 1ns/1ps
// Self-checking bench for cam_cmd_issue: directed scenarios plus random traffic
// against a queue-based transaction model of the command buffer.
module tb_cam_cmd_issue;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } cmd_t;

    logic          clk_i;
    logic          reset_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [AW-1:0] cmd_index_i;
    logic [DW-1:0] cmd_data_i;
    logic          hold_i;
    logic          read_o;
    logic [AW-1:0] read_index_o;
    logic          write_o;
    logic [AW-1:0] write_index_o;
    logic [DW-1:0] write_data_o;
    logic          search_o;
    logic [DW-1:0] search_data_o;
    logic [CW-1:0] count_o;
    logic          illegal_o;

    cam_cmd_issue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_index_i(cmd_index_i), .cmd_data_i(cmd_data_i),
        .hold_i(hold_i),
        .read_o(read_o), .read_index_o(read_index_o),
        .write_o(write_o), .write_index_o(write_index_o), .write_data_o(write_data_o),
        .search_o(search_o), .search_data_o(search_data_o),
        .count_o(count_o), .illegal_o(illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: commands waiting, the one in flight, and expected outputs.
    cmd_t          m_q[$];
    cmd_t          m_iss;
    logic          m_iss_v;
    logic          e_read, e_write, e_search, e_illegal;
    logic [AW-1:0] e_ridx, e_widx;
    logic [DW-1:0] e_wdata, e_sdata;

    int tests = 0;
    int fails = 0;
    int n_strobe = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_iss_v   = 1'b0;
        m_iss     = '0;
        e_read    = 1'b0; e_write = 1'b0; e_search = 1'b0; e_illegal = 1'b0;
        e_ridx    = '0;   e_widx  = '0;   e_wdata  = '0;   e_sdata   = '0;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ":read_o"},        DW'(read_o),        DW'(e_read));
        check({ph, ":write_o"},       DW'(write_o),       DW'(e_write));
        check({ph, ":search_o"},      DW'(search_o),      DW'(e_search));
        check({ph, ":illegal_o"},     DW'(illegal_o),     DW'(e_illegal));
        check({ph, ":read_index_o"},  DW'(read_index_o),  DW'(e_ridx));
        check({ph, ":write_index_o"}, DW'(write_index_o), DW'(e_widx));
        check({ph, ":write_data_o"},  write_data_o,       e_wdata);
        check({ph, ":search_data_o"}, search_data_o,      e_sdata);
        check({ph, ":count_o"},       DW'(count_o),       DW'(m_q.size()));
    endtask

    // One clock of stimulus; the model advances at the edge and outputs are checked 1ns later.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [AW-1:0] idx,
                         input logic [DW-1:0] d, input logic hold, output logic acc);
        logic ready, pop, byp;
        cmd_t c;
        cmd_valid_i = v; cmd_op_i = op; cmd_index_i = idx; cmd_data_i = d; hold_i = hold;
        #1;
        ready = (m_q.size() < FD);
        check("cmd_ready_o", DW'(cmd_ready_o), DW'(ready));
        c   = '{op: op, idx: idx, data: d};
        acc = v && ready;
        @(posedge clk_i);
        e_read   = m_iss_v && (m_iss.op == 2'b01);
        e_write  = m_iss_v && (m_iss.op == 2'b10);
        e_search = m_iss_v && (m_iss.op == 2'b11);
        if (e_read)   e_ridx = m_iss.idx;
        if (e_write)  begin e_widx = m_iss.idx; e_wdata = m_iss.data; end
        if (e_search) e_sdata = m_iss.data;
        e_illegal = acc && (op == 2'b00);
        pop = (m_q.size() > 0) && !hold;
        byp = 1'b0;
`ifdef CAM_CMD_BYPASS_EN
        byp = acc && (op != 2'b00) && (m_q.size() == 0) && !hold;
`endif
        m_iss_v = pop || byp;
        if (pop)      m_iss = m_q.pop_front();
        else if (byp) m_iss = c;
        if (acc && (op != 2'b00) && !byp) m_q.push_back(c);
        #1;
        check_outputs("cyc");
        if (read_o || write_o || search_o) n_strobe++;
    endtask

    task automatic idle(input int n, input logic hold);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, '0, hold, a);
    endtask

    task automatic do_reset();
        cmd_valid_i = 1'b0;
        reset_i = 1'b1;
        #2;
        model_clear();
        check_outputs("rst");
        check("rst:cmd_ready_o", DW'(cmd_ready_o), DW'(1'b1));
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("rel:cmd_ready_o", DW'(cmd_ready_o), DW'(1'b1));
    endtask

    initial begin
        logic a;
        int   base, sent, budget;
        logic seen;
        logic [1:0] op;
        reset_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 2'b00;
        cmd_index_i = '0; cmd_data_i = '0; hold_i = 1'b0;
        model_clear();
        #3;
        do_reset();

        // Single write: strobe two edges after acceptance (one with bypass).
        cycle(1'b1, 2'b10, 5'd3, 32'hDEADBEEF, 1'b0, a);
        check("w:accepted", DW'(a), DW'(1'b1));
`ifdef CAM_CMD_BYPASS_EN
        cycle(1'b0, 2'b00, '0, '0, 1'b0, a);
`else
        cycle(1'b0, 2'b00, '0, '0, 1'b0, a);
        check("w:no_early_strobe", DW'(write_o), DW'(1'b0));
        cycle(1'b0, 2'b00, '0, '0, 1'b0, a);
`endif
        check("w:write_o", DW'(write_o), DW'(1'b1));
        check("w:write_index_o", DW'(write_index_o), DW'(5'd3));
        check("w:write_data_o", write_data_o, 32'hDEADBEEF);
        idle(2, 1'b0);

        // Fill under hold; fifth command must stall; drain back-to-back.
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'(1 + i % 3), AW'(i + 8), DW'(32'h1000 + i), 1'b1, a);
        check("full:count_o", DW'(count_o), DW'(4));
        cycle(1'b1, 2'b01, 5'd20, 32'h0, 1'b1, a);
        check("full:fifth_held", DW'(a), DW'(1'b0));
        check("full:cmd_ready_o", DW'(cmd_ready_o), DW'(1'b0));
        base = n_strobe;
        idle(6, 1'b0);
        check("drain:strobes", DW'(n_strobe - base), DW'(4));

        // Full FIFO then continuous valid: simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'b10, AW'(i), DW'(32'hA000 + i), 1'b1, a);
        sent = 0; budget = 0;
        while (sent < 12 && budget < 40) begin
            cycle(1'b1, 2'(1 + sent % 3), AW'(sent), DW'(32'hB000 + sent), 1'b0, a);
            if (budget == 0) check("stream:count_after_pop", DW'(count_o), DW'(3));
            if (a) sent++;
            budget++;
        end
        check("stream:all_sent", DW'(sent), DW'(12));
        idle(8, 1'b0);

        // Illegal op: one pulse, nothing enqueued, no strobe.
        base = n_strobe;
        cycle(1'b1, 2'b00, 5'd9, 32'h0, 1'b0, a);
        check("ill:illegal_o", DW'(illegal_o), DW'(1'b1));
        check("ill:count_o", DW'(count_o), DW'(0));
        idle(4, 1'b0);
        check("ill:no_strobe", DW'(n_strobe - base), DW'(0));

        // Reset mid-stream with commands buffered and one in the issue stage.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, AW'(i + 1), '0, 1'b1, a);
        cycle(1'b0, 2'b00, '0, '0, 1'b0, a);
        do_reset();
        base = n_strobe;
        idle(6, 1'b0);
        check("rstmid:no_strobe", DW'(n_strobe - base), DW'(0));
        check("rstmid:count_o", DW'(count_o), DW'(0));

        // Read then search: read index holds through the search issue.
        cycle(1'b1, 2'b01, 5'd7, 32'h0, 1'b0, a);
        cycle(1'b1, 2'b11, 5'd0, 32'h5A5A5A5A, 1'b0, a);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            cycle(1'b0, 2'b00, '0, '0, 1'b0, a);
            seen = search_o;
        end
        check("rs:search_seen", DW'(seen), DW'(1'b1));
        check("rs:read_index_o", DW'(read_index_o), DW'(5'd7));
        check("rs:search_data_o", search_data_o, 32'h5A5A5A5A);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), op, AW'($urandom), DW'($urandom),
                  ($urandom_range(0, 3) == 0), a);
        end
        idle(10, 1'b0);
        check("end:count_o", DW'(count_o), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
